// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned BURST_DEF = 4;
  localparam int unsigned BCNT_W    = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req at or above rr_ptr, wrapping to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] pick,
  output logic [IDW-1:0]  pick_id,
  output logic            any
);

  always_comb begin
    logic [IDW-1:0] idx;
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        pick_id   = idx;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// granting bursts of up to BURST words with an idle bubble between grants.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = NREQ_DEF,
  parameter  int unsigned DSIZE = DSIZE_DEF,
  parameter  int unsigned BURST = BURST_DEF,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*DSIZE-1:0] din,
  output logic [NREQ-1:0]       gnt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        gnt_id,
  output logic                  busy
);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [NREQ-1:0]   pick;
  logic [IDW-1:0]    pick_id;
  logic              pick_any;

  logic              cur_req;
  logic              cur_last;
  logic              xfer;
  logic              rel;
  logic [BCNT_W-1:0] burst_nxt;
  logic [IDW-1:0]    ptr_after;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .pick_id(pick_id),
    .any    (pick_any)
  );

  assign busy     = (state_q == GRANT);
  assign cur_req  = req[gnt_id_q];
  assign cur_last = last[gnt_id_q];
  // A word presented while reset is asserted belongs to an abandoned burst.
  assign xfer     = busy & cur_req & ~wfull & ~wrst;

  assign winc   = xfer;
  assign wdata  = din[32'(gnt_id_q)*DSIZE +: DSIZE];
  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;

  assign burst_nxt = burst_cnt_q + BCNT_W'(1);
  assign rel       = ~cur_req | (xfer & (cur_last | (burst_nxt == BCNT_W'(BURST))));
  assign ptr_after = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          gnt_d       = pick;
          gnt_id_d    = pick_id;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_cnt_d = burst_nxt;
        end
        if (rel) begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          rr_ptr_d = ptr_after;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle vector table plus
// requester-model sequences for bursts, back-pressure, drops and reset.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  logic        wclk = 1'b0;
  logic        wrst, wfull;
  logic [3:0]  req, last, gnt;
  logic [31:0] din;
  logic        winc, busy;
  logic [7:0]  wdata;
  logic [1:0]  gnt_id;

  logic        wrst2, wfull2, winc2, busy2;
  logic [3:0]  req2, last2, gnt2;
  logic [31:0] din2;
  logic [7:0]  wdata2;
  logic [1:0]  gnt_id2;

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .last(last), .din(din), .gnt(gnt),
    .wfull(wfull), .winc(winc), .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
  );

  fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .BURST(2)) dut2 (
    .wclk(wclk), .wrst(wrst2), .req(req2), .last(last2), .din(din2), .gnt(gnt2),
    .wfull(wfull2), .winc(winc2), .wdata(wdata2), .gnt_id(gnt_id2), .busy(busy2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       wfull;
    logic [3:0] e_gnt;
    logic       e_winc;
    logic       e_busy;
    logic [1:0] e_id;
  } vec_t;
  vec_t tv[17];

  // Requester model state and observations.
  int         left[4];
  int         idx[4];
  bit         use_last[4];
  int         got_w[$], exp_w[$], got_ep[$], exp_ep[$], got_p[$], exp_p[$];
  logic [3:0] prev_gnt;
  logic [3:0] s_gnt;
  logic       s_winc, s_busy;
  logic [7:0] s_bcnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_q(input string name, input int got[$], input int want[$]);
    bit ok;
    ok = (got.size() == want.size());
    if (ok) for (int i = 0; i < got.size(); i++) if (got[i] != want[i]) ok = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%p want=%p", name, got, want);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req[i]         = (left[i] != 0);
      last[i]        = use_last[i] && (left[i] == 1);
      din[i*8 +: 8]  = 8'(i*64 + idx[i]);
    end
  endtask

  task automatic tick();
    bit w;
    int g;
    @(negedge wclk);
    s_gnt  = gnt;
    s_winc = winc;
    s_busy = busy;
    s_bcnt = dut.burst_cnt_q;
    if (gnt != 4'b0 && gnt != prev_gnt) begin
      got_ep.push_back(int'(gnt_id) * 16);
      got_p.push_back(int'(dut.rr_ptr_q));
    end
    w = winc;
    g = int'(gnt_id);
    if (winc) begin
      got_w.push_back(int'(wdata));
      if (got_ep.size() > 0) got_ep[got_ep.size()-1] = got_ep[got_ep.size()-1] + 1;
    end
    prev_gnt = gnt;
    @(posedge wclk);
    #1;
    if (w) begin
      idx[g]++;
      left[g]--;
    end
    drive_reqs();
  endtask

  task automatic run_idle(input string name, input int budget);
    bit done;
    int sum;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      sum = 0;
      for (int i = 0; i < 4; i++) sum += left[i];
      if (sum == 0 && !busy) done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles, busy=%0b", name, budget, busy);
    end
  endtask

  task automatic reset_dut();
    wrst  = 1'b1;
    wfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i]     = 0;
      idx[i]      = 0;
      use_last[i] = 1;
    end
    drive_reqs();
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;
    got_w.delete();  exp_w.delete();
    got_ep.delete(); exp_ep.delete();
    got_p.delete();  exp_p.delete();
    prev_gnt = 4'b0;
  endtask

  initial begin
    logic [3:0] p2;
    wrst2  = 1'b1;
    req2   = 4'hF;
    last2  = 4'h0;
    wfull2 = 1'b0;
    din2   = 32'h33221100;

    //         req    last   wf    gnt    winc  busy  id
    tv[0]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};
    tv[1]  = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};
    tv[2]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[3]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[4]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[5]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[6]  = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};
    tv[7]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[8]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[9]  = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};
    tv[10] = '{4'h1, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 2'd0};
    tv[11] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 2'd0};
    tv[12] = '{4'h9, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};
    tv[13] = '{4'h9, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 2'd3};
    tv[14] = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};
    tv[15] = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0};
    tv[16] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0};

    // Per-cycle vectors: outputs expected within the same cycle the inputs apply.
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      logic [7:0] exp_wd;
      req    = tv[i].req;
      last   = tv[i].last;
      wfull  = tv[i].wfull;
      din    = 32'hA3A2A1A0;
      exp_wd = 8'hA0 + 8'(tv[i].e_id);
      @(negedge wclk);
      check($sformatf("vec%0d", i), {gnt, winc, busy, gnt_id, wdata},
            {tv[i].e_gnt, tv[i].e_winc, tv[i].e_busy, tv[i].e_id, exp_wd});
      @(posedge wclk);
      #1;
    end

    // Single requester, 6 words, BURST=4: 4 + bubble + 2.
    reset_dut();
    left[0] = 6;
    drive_reqs();
    tick();
    check("single_idle_first", 64'(s_gnt), 64'h0);
    tick();
    check("single_gnt_latency", 64'(s_gnt), 64'h1);
    run_idle("single_drain", 40);
    exp_w  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_ep = '{0*16+4, 0*16+2};
    check_q("single_words", got_w, exp_w);
    check_q("single_bursts", got_ep, exp_ep);

    // All four requesting continuously on the BURST=2 instance.
    repeat (2) @(posedge wclk);
    #1;
    wrst2 = 1'b0;
    got_ep.delete(); got_p.delete();
    p2 = 4'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge wclk);
      if (gnt2 != 4'b0 && gnt2 != p2) begin
        got_ep.push_back(int'(gnt_id2) * 16);
        got_p.push_back(int'(dut2.rr_ptr_q));
      end
      if (winc2 && got_ep.size() > 0) got_ep[got_ep.size()-1] = got_ep[got_ep.size()-1] + 1;
      p2 = gnt2;
    end
    wrst2  = 1'b1;
    exp_ep = '{0*16+2, 1*16+2, 2*16+2, 3*16+2, 0*16+2};
    exp_p  = '{0, 1, 2, 3, 0};
    check_q("rr_order", got_ep, exp_ep);
    check_q("rr_ptr_seq", got_p, exp_p);

    // wfull stall of 5 cycles after two words of requester 2.
    reset_dut();
    left[2] = 4;
    drive_reqs();
    repeat (3) tick();
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall%0d", c), {s_winc, s_gnt, s_bcnt}, {1'b0, 4'b0100, 8'd2});
    end
    wfull = 1'b0;
    run_idle("stall_drain", 20);
    exp_w  = '{8'h80, 8'h81, 8'h82, 8'h83};
    exp_ep = '{2*16+4};
    check_q("stall_words", got_w, exp_w);
    check_q("stall_bursts", got_ep, exp_ep);

    // Requester 1 drops req after one word; requester 3 pending.
    reset_dut();
    left[1]     = 1;
    use_last[1] = 0;
    left[3]     = 2;
    drive_reqs();
    repeat (3) tick();
    check("drop_hold", {s_gnt, s_winc}, {4'b0010, 1'b0});
    tick();
    check("drop_bubble", 64'(s_gnt), 64'h0);
    tick();
    check("drop_next", 64'(s_gnt), 64'h8);
    run_idle("drop_drain", 20);
    exp_w  = '{8'h40, 8'hC0, 8'hC1};
    exp_ep = '{1*16+1, 3*16+2};
    exp_p  = '{0, 2};
    check_q("drop_words", got_w, exp_w);
    check_q("drop_bursts", got_ep, exp_ep);
    check_q("drop_ptr", got_p, exp_p);

    // Reset pulse mid-burst on requester 3 after two words.
    reset_dut();
    left[3] = 6;
    drive_reqs();
    repeat (3) tick();
    wrst = 1'b1;
    tick();
    check("rst_pre", {s_gnt, s_winc, s_bcnt}, {4'b1000, 1'b0, 8'd2});
    wrst    = 1'b0;
    left[0] = 2;
    drive_reqs();
    tick();
    check("rst_after", {s_gnt, s_winc, s_busy}, {4'b0, 1'b0, 1'b0});
    run_idle("rst_drain", 40);
    exp_w  = '{8'hC0, 8'hC1, 8'h00, 8'h01, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    exp_ep = '{3*16+2, 0*16+2, 3*16+4};
    check_q("rst_words", got_w, exp_w);
    check_q("rst_bursts", got_ep, exp_ep);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters sharing the FIFO write port.
REQ-002 Parameter DSIZE, default 8: data width, equal to the FIFO DSIZE.
REQ-003 Parameter BURST, default 4: maximum transfers per grant (range 1..255).
REQ-004 Port wclk  input  1: write-domain clock; one clock only, all logic on its rising edge.
REQ-005 Port wrst  input  1: reset, synchronous, active-high.
REQ-006 Port req  input  NREQ: per-requester write request, held until granted and transferred.
REQ-007 Port last  input  NREQ: per-requester end-of-burst marker, qualified with its req.
REQ-008 Port din  input  NREQ*DSIZE: requester data; lane i is din[i*DSIZE +: DSIZE].
REQ-009 Port gnt  output  NREQ: one-hot grant, or all zero.
REQ-010 Port wfull  input  1: FIFO full flag.
REQ-011 Port winc  output  1: FIFO write enable.
REQ-012 Port wdata  output  DSIZE: FIFO write data.
REQ-013 Port gnt_id  output  $clog2(NREQ): index of the granted requester; 0 when idle.
REQ-014 Port busy  output  1: high while in GRANT state.

Function
REQ-015 FSM has two states, IDLE and GRANT; gnt is registered and nonzero only in GRANT.
REQ-016 IDLE with any req high: next cycle is GRANT; gnt is one-hot on the first requester with req high, searching from rr_ptr upward with wrap-around from NREQ-1 to 0.
REQ-017 IDLE with req == 0: stay in IDLE; gnt = 0.
REQ-018 Grant latency: req rising in IDLE at cycle t gives gnt at cycle t+1.
REQ-019 winc = busy & req[gnt_id] & ~wfull, combinational; wdata = din lane gnt_id, combinational.
REQ-020 A transfer is a cycle with winc = 1; exactly one FIFO write occurs per transfer.
REQ-021 burst_cnt (8 bits) clears on entry to GRANT and increments by 1 per transfer.
REQ-022 Release occurs, at the end of a GRANT cycle, on any one of the following:
  - a transfer with last[gnt_id] = 1;
  - a transfer that makes burst_cnt equal to BURST;
  - req[gnt_id] = 0.
REQ-023 On release: next state is IDLE and rr_ptr becomes (gnt_id+1) mod NREQ.
REQ-024 Release always passes through one IDLE bubble cycle; no back-to-back grants occur.
REQ-025 wfull high in GRANT: winc = 0; grant, burst_cnt and rr_ptr hold; no timeout.
REQ-026 wfull and release by req drop in the same cycle: release applies and no write occurs.
REQ-027 Requests of non-granted requesters are ignored and never preempt the current grant.
REQ-028 Starvation bound: a requester holding req waits at most NREQ-1 grants.
REQ-029 winc is never high when gnt = 0 or when wfull = 1.

Reset
REQ-030 While wrst is high at a wclk edge, the block takes its reset values on that edge:
  - state IDLE, rr_ptr 0, burst_cnt 0;
  - gnt 0, gnt_id 0, busy 0, winc 0.
REQ-031 Reset asserted mid-burst drops the grant on the next edge; the partial burst is abandoned and its in-flight word is not written.
REQ-032 Arbitration starts on the first edge after wrst deasserts, from rr_ptr = 0.

Structure
REQ-033 Shared package fifo_arb_pkg holds:
  - the state enum arb_state_t {IDLE, GRANT};
  - default constants for NREQ, DSIZE and BURST;
  - the burst counter width constant (8).
REQ-034 Combinational sub-module rr_pick(req, rr_ptr -> one-hot pick, pick_id, any) performs the rotating priority search.
REQ-035 Outputs drive the FIFO write-side winc and wdata directly, and wfull is taken from the FIFO write side; no clock crossing occurs in this block.

Verification
REQ-036 Single requester: req[0] = 1 for 6 words, last on word 6, BURST = 4.
  - Required: gnt = 0001 one cycle after req; 4 winc pulses; IDLE bubble; regrant; 2 more writes.
  - Required: FIFO receives the 6 words in order.
REQ-037 All four requesters request continuously, BURST = 2.
  - Required: grant order 0, 1, 2, 3, 0, each with exactly 2 writes.
  - Required: rr_ptr follows 1, 2, 3, 0.
REQ-038 wfull forced high for 5 cycles mid-burst on requester 2.
  - Required: winc = 0 for those 5 cycles; gnt stays 0100; burst_cnt holds.
  - Required: writes resume when wfull falls, with no lost or duplicated word.
REQ-039 Requester 1 drops req after 1 transfer while granted.
  - Required: release after that cycle; rr_ptr = 2; requester 3 granted next when it is pending.
REQ-040 wrst pulsed for 1 cycle while gnt = 1000 with burst_cnt = 2.
  - Required: next cycle gnt = 0, winc = 0, busy = 0.
  - Required: with req[0] and req[3] both high afterwards, first grant goes to requester 0.
